vedic_mul16_seq_ctrl: RTL and testbench

//   Area-reduced 16x16 unsigned multiplier controller. Sequences a single

---
 rtl/vedic_mul16_seq_ctrl.sv | 172 +++++++++++++++++
 tb/tb_vedic_mul16_seq_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/vedic_mul16_seq_ctrl.sv
// Sequential 16x16 unsigned multiplier: one 8x8 Vedic core walks the four
// partial products over four cycles and shift-accumulates them into the product.

module vedic2x2 (
   input  logic [1:0] a,
   input  logic [1:0] b,
   output logic [3:0] p
);
   logic t1, t2, t3, c1;

   always_comb begin
      t1   = a[1] & b[0];
      t2   = a[0] & b[1];
      t3   = a[1] & b[1];
      c1   = t1 & t2;
      p[0] = a[0] & b[0];
      p[1] = t1 ^ t2;
      p[2] = t3 ^ c1;
      p[3] = t3 & c1;
   end
endmodule

module vedic4x4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [7:0] p
);
   logic [3:0] q0, q1, q2, q3;
   logic [5:0] upper;

   vedic2x2 u_ll (.a(a[1:0]), .b(b[1:0]), .p(q0));
   vedic2x2 u_hl (.a(a[3:2]), .b(b[1:0]), .p(q1));
   vedic2x2 u_lh (.a(a[1:0]), .b(b[3:2]), .p(q2));
   vedic2x2 u_hh (.a(a[3:2]), .b(b[3:2]), .p(q3));

   // The low two bits come straight from lo*lo; everything else is summed above them.
   always_comb begin
      upper = {4'b0, q0[3:2]} + {2'b0, q1} + {2'b0, q2} + {q3, 2'b0};
      p     = {upper, q0[1:0]};
   end
endmodule

module Vedic8x8_Top (
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic [15:0] p
);
   logic [7:0]  q0, q1, q2, q3;
   logic [11:0] upper;

   vedic4x4 u_ll (.a(a[3:0]), .b(b[3:0]), .p(q0));
   vedic4x4 u_hl (.a(a[7:4]), .b(b[3:0]), .p(q1));
   vedic4x4 u_lh (.a(a[3:0]), .b(b[7:4]), .p(q2));
   vedic4x4 u_hh (.a(a[7:4]), .b(b[7:4]), .p(q3));

   always_comb begin
      upper = {8'b0, q0[7:4]} + {4'b0, q1} + {4'b0, q2} + {q3, 4'b0};
      p     = {upper, q0[3:0]};
   end
endmodule

module vedic_mul16_seq_ctrl #(
   parameter int WIDTH     = 16,
   parameter int CNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       A_in,
   input  logic [WIDTH-1:0]       B_in,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [2*WIDTH-1:0]     Q,
   output logic                   busy,
   output logic [CNT_WIDTH-1:0]   op_count
);
   localparam int HALF = WIDTH / 2;

   typedef enum logic [2:0] {
      IDLE,
      PP0,
      PP1,
      PP2,
      PP3,
      DONE
   } state_t;

   state_t                 state, state_next;
   logic [WIDTH-1:0]       a_reg, b_reg;
   logic [2*WIDTH-1:0]     acc, acc_next, q_reg, pp_ext;
   logic [HALF-1:0]        core_a, core_b;
   logic [WIDTH-1:0]       pp;

   Vedic8x8_Top u_core (
      .a (core_a),
      .b (core_b),
      .p (pp)
   );

   always_comb begin
      pp_ext = {{WIDTH{1'b0}}, pp};
   end

   always_comb begin
      state_next = state;
      acc_next   = acc;
      core_a     = a_reg[HALF-1:0];
      core_b     = b_reg[HALF-1:0];
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b1;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) state_next = PP0;
         end
         PP0: begin
            acc_next   = acc + pp_ext;
            state_next = PP1;
         end
         PP1: begin
            core_a     = a_reg[WIDTH-1:HALF];
            acc_next   = acc + (pp_ext << HALF);
            state_next = PP2;
         end
         PP2: begin
            core_b     = b_reg[WIDTH-1:HALF];
            acc_next   = acc + (pp_ext << HALF);
            state_next = PP3;
         end
         PP3: begin
            core_a     = a_reg[WIDTH-1:HALF];
            core_b     = b_reg[WIDTH-1:HALF];
            acc_next   = acc + (pp_ext << WIDTH);
            state_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Q has its own register so it keeps the last product while acc is reused.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         a_reg    <= '0;
         b_reg    <= '0;
         acc      <= '0;
         q_reg    <= '0;
         op_count <= '0;
      end else begin
         state <= state_next;
         if (state == IDLE && in_valid) begin
            a_reg <= A_in;
            b_reg <= B_in;
            acc   <= '0;
         end else begin
            acc <= acc_next;
         end
         if (state == PP3) q_reg <= acc_next;
         if (state == DONE && out_ready && op_count != '1)
            op_count <= op_count + CNT_WIDTH'(1);
      end
   end

   assign Q = q_reg;
endmodule

// File: tb/tb_vedic_mul16_seq_ctrl.sv
// Self-checking bench for vedic_mul16_seq_ctrl: directed vector table,
// reset-abort sequence and random operands checked against plain A*B.

module tb_vedic_mul16_seq_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic [15:0] A_in, B_in;
   logic        out_valid, out_ready;
   logic [31:0] Q;
   logic        busy;
   logic [15:0] op_count;

   int checks = 0;
   int errors = 0;
   int exp_count = 0;

   vedic_mul16_seq_ctrl #(.WIDTH(16), .CNT_WIDTH(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A_in      (A_in),
      .B_in      (B_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Q         (Q),
      .busy      (busy),
      .op_count  (op_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [31:0] q;
      int          hold;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full transaction; operands and in_valid are scrambled while busy.
   task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                         input int hold, input logic [31:0] exp);
      int          lat;
      logic [31:0] q0;
      in_valid  = 1'b1;
      A_in      = a;
      B_in      = b;
      out_ready = 1'b0;
      chk("in_ready_idle", {31'b0, in_ready}, 32'd1);
      step();
      lat = 0;
      for (int i = 0; i < 12 && !out_valid; i++) begin
         chk("busy_running", {31'b0, busy}, 32'd1);
         chk("in_ready_running", {31'b0, in_ready}, 32'd0);
         in_valid = 1'($urandom);
         A_in     = 16'($urandom);
         B_in     = 16'($urandom);
         step();
         lat++;
      end
      chk("latency", 32'(lat), 32'd4);
      chk("out_valid", {31'b0, out_valid}, 32'd1);
      chk("product", Q, exp);
      q0 = Q;
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'($urandom);
         A_in     = 16'($urandom);
         B_in     = 16'($urandom);
         step();
         chk("hold_valid", {31'b0, out_valid}, 32'd1);
         chk("hold_q", Q, q0);
         chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      if (exp_count < 65535) exp_count++;
      chk("idle_after", {31'b0, in_ready}, 32'd1);
      chk("valid_low_after", {31'b0, out_valid}, 32'd0);
      chk("busy_low_after", {31'b0, busy}, 32'd0);
      chk("op_count", {16'b0, op_count}, 32'(exp_count));
      chk("q_kept", Q, exp);
   endtask

   initial begin
      vecs[0] = '{16'h1234, 16'h5678, 32'h06260060, 0};
      vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001, 0};
      vecs[2] = '{16'h0000, 16'hBEEF, 32'h00000000, 0};
      vecs[3] = '{16'h0100, 16'h0100, 32'h00010000, 0};
      vecs[4] = '{16'h1234, 16'h5678, 32'h06260060, 7};
      vecs[5] = '{16'hFFFF, 16'h0001, 32'h0000FFFF, 2};

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      A_in      = '0;
      B_in      = '0;
      step();
      step();
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_q", Q, 32'd0);
      chk("rst_op_count", {16'b0, op_count}, 32'd0);
      rst = 1'b0;

      // Abort an operation in PP2 with a reset.
      in_valid = 1'b1;
      A_in     = 16'h1234;
      B_in     = 16'h5678;
      step();
      in_valid = 1'b0;
      step();
      step();
      chk("abort_busy_before", {31'b0, busy}, 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
      chk("abort_busy", {31'b0, busy}, 32'd0);
      chk("abort_q", Q, 32'd0);
      chk("abort_op_count", {16'b0, op_count}, 32'd0);
      begin
         logic seen = 1'b0;
         for (int i = 0; i < 8; i++) begin
            step();
            if (out_valid) seen = 1'b1;
         end
         chk("abort_no_output", {31'b0, seen}, 32'd0);
      end

      for (int i = 0; i < 6; i++)
         run_op(vecs[i].a, vecs[i].b, vecs[i].hold, vecs[i].q);

      for (int i = 0; i < 40; i++) begin
         logic [15:0] a, b;
         a = 16'($urandom);
         b = 16'($urandom);
         run_op(a, b, int'($urandom_range(0, 3)), {16'b0, a} * {16'b0, b});
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
